// File: rtl/vedic_seq_divider.sv
// Iterative restoring divider: one shift-subtract step per clock, valid/ready on both sides.
// Optional two's-complement operation is enabled by defining VEDIC_DIV_SIGNED_EN.
module vedic_seq_divider #(
    parameter int DIVIDER_WIDTH = 32
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [DIVIDER_WIDTH-1:0] dividend_div,
    input  logic [DIVIDER_WIDTH-1:0] divisor_div,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [DIVIDER_WIDTH-1:0] quotient_div,
    output logic [DIVIDER_WIDTH-1:0] remainder_div,
    output logic                     div_by_zero
);
    localparam int W  = DIVIDER_WIDTH;
    localparam int CW = $clog2(W + 1);

    typedef enum logic [1:0] {IDLE, RUN, FIX, DONE} state_t;

    state_t         state;
    logic [W-1:0]   dvd;
    logic [W-1:0]   dvs;
    logic [W-1:0]   rem;
    logic [CW-1:0]  cnt;
    logic [W:0]     shifted;
    logic [W:0]     diff;
    logic           qbit;
    logic [W-1:0]   q_next;
    logic [W-1:0]   r_next;
    logic [W-1:0]   a_in;
    logic [W-1:0]   b_in;

`ifdef VEDIC_DIV_SIGNED_EN
    logic           qneg;
    logic           rneg;

    always_comb begin
        a_in = dividend_div[W-1] ? -dividend_div : dividend_div;
        b_in = divisor_div[W-1] ? -divisor_div : divisor_div;
    end
`else
    always_comb begin
        a_in = dividend_div;
        b_in = divisor_div;
    end
`endif

    // Quotient bits shift into the dividend register as its bits are consumed.
    always_comb begin
        shifted = {rem, dvd[W-1]};
        diff    = shifted - {1'b0, dvs};
        qbit    = ~diff[W];
        q_next  = {dvd[W-2:0], qbit};
        r_next  = qbit ? diff[W-1:0] : shifted[W-1:0];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= IDLE;
            in_ready      <= 1'b1;
            out_valid     <= 1'b0;
            quotient_div  <= '0;
            remainder_div <= '0;
            div_by_zero   <= 1'b0;
            cnt           <= '0;
            dvd           <= '0;
            dvs           <= '0;
            rem           <= '0;
`ifdef VEDIC_DIV_SIGNED_EN
            qneg          <= 1'b0;
            rneg          <= 1'b0;
`endif
        end else begin
            unique case (state)
                IDLE: begin
                    if (in_valid) begin
                        in_ready <= 1'b0;
                        if (divisor_div == '0) begin
                            quotient_div  <= '1;
                            remainder_div <= dividend_div;
                            div_by_zero   <= 1'b1;
                            out_valid     <= 1'b1;
                            state         <= DONE;
                        end else begin
                            dvd   <= a_in;
                            dvs   <= b_in;
                            rem   <= '0;
                            cnt   <= CW'(W);
                            state <= RUN;
`ifdef VEDIC_DIV_SIGNED_EN
                            qneg  <= dividend_div[W-1] ^ divisor_div[W-1];
                            rneg  <= dividend_div[W-1];
`endif
                        end
                    end
                end
                RUN: begin
                    dvd <= q_next;
                    rem <= r_next;
                    cnt <= cnt - 1'b1;
                    if (cnt == CW'(1)) begin
`ifdef VEDIC_DIV_SIGNED_EN
                        state         <= FIX;
`else
                        quotient_div  <= q_next;
                        remainder_div <= r_next;
                        div_by_zero   <= 1'b0;
                        out_valid     <= 1'b1;
                        state         <= DONE;
`endif
                    end
                end
`ifdef VEDIC_DIV_SIGNED_EN
                FIX: begin
                    quotient_div  <= qneg ? -dvd : dvd;
                    remainder_div <= rneg ? -rem : rem;
                    div_by_zero   <= 1'b0;
                    out_valid     <= 1'b1;
                    state         <= DONE;
                end
`endif
                DONE: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        in_ready  <= 1'b1;
                        state     <= IDLE;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_vedic_seq_divider.sv
// Directed and randomised checks of vedic_seq_divider at 32-bit width.
// Signed vectors are exercised only when VEDIC_DIV_SIGNED_EN is defined.
module tb_vedic_seq_divider;
    localparam int W = 32;
`ifdef VEDIC_DIV_SIGNED_EN
    localparam int LAT = W + 1;
`else
    localparam int LAT = W;
`endif

    logic         clk = 1'b0;
    logic         rst;
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] dividend_div;
    logic [W-1:0] divisor_div;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] quotient_div;
    logic [W-1:0] remainder_div;
    logic         div_by_zero;

    int n_cmp = 0;
    int n_err = 0;

    vedic_seq_divider #(.DIVIDER_WIDTH(W)) dut (
        .clk          (clk),
        .rst          (rst),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .dividend_div (dividend_div),
        .divisor_div  (divisor_div),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .quotient_div (quotient_div),
        .remainder_div(remainder_div),
        .div_by_zero  (div_by_zero)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got,
                         input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic start(input logic [W-1:0] a, input logic [W-1:0] b);
        @(negedge clk);
        dividend_div = a;
        divisor_div  = b;
        in_valid     = 1'b1;
        check("in_ready_before_accept", 64'(in_ready), 64'd1);
        @(posedge clk);
        #1 in_valid = 1'b0;
    endtask

    // Counts edges after the accept edge until out_valid is seen.
    task automatic wait_out(output int lat);
        lat = 0;
        while (!out_valid && lat < 200) begin
            @(posedge clk);
            #1;
            lat++;
        end
    endtask

    task automatic handshake();
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        check("out_valid_after_hs", 64'(out_valid), 64'd0);
        check("in_ready_after_hs", 64'(in_ready), 64'd1);
    endtask

    task automatic run_op(input string tag, input logic [W-1:0] a,
                          input logic [W-1:0] b, input logic [W-1:0] eq,
                          input logic [W-1:0] er, input logic ez,
                          input int elat);
        int lat;
        out_ready = 1'b0;
        start(a, b);
        wait_out(lat);
        check({tag, "_lat"}, 64'(lat), 64'(elat));
        check({tag, "_q"}, 64'(quotient_div), 64'(eq));
        check({tag, "_r"}, 64'(remainder_div), 64'(er));
        check({tag, "_dbz"}, 64'(div_by_zero), 64'(ez));
        handshake();
    endtask

    initial begin
        int lat;
        bit stable;
        bit saw_valid;
        logic [W-1:0] a;
        logic [W-1:0] b;
        rst          = 1'b1;
        in_valid     = 1'b0;
        out_ready    = 1'b0;
        dividend_div = '0;
        divisor_div  = '0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_in_ready", 64'(in_ready), 64'd1);
        check("rst_out_valid", 64'(out_valid), 64'd0);
        check("rst_q", 64'(quotient_div), 64'd0);
        check("rst_r", 64'(remainder_div), 64'd0);
        check("rst_dbz", 64'(div_by_zero), 64'd0);
        rst = 1'b0;

        run_op("t1_100_7", 32'd100, 32'd7, 32'd14, 32'd2, 1'b0, LAT);
        run_op("t2_div0", 32'h1234, 32'd0, 32'hFFFF_FFFF, 32'h1234, 1'b1, 0);

        out_ready = 1'b0;
        start(32'hFFFF_FFFF, 32'd1);
        wait_out(lat);
        check("t3_lat", 64'(lat), 64'(LAT));
        stable = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            in_valid     = 1'b1;
            dividend_div = 32'd55;
            divisor_div  = 32'd5;
            if (quotient_div !== 32'hFFFF_FFFF || remainder_div !== 32'd0 ||
                out_valid !== 1'b1 || in_ready !== 1'b0)
                stable = 1'b0;
        end
        in_valid = 1'b0;
        check("t3_hold_stable", 64'(stable), 64'd1);
        check("t3_q", 64'(quotient_div), 64'hFFFF_FFFF);
        check("t3_r", 64'(remainder_div), 64'd0);
        handshake();

        out_ready = 1'b1;
        start(32'd1000, 32'd3);
        repeat (15) @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        check("t4_rst_out_valid", 64'(out_valid), 64'd0);
        check("t4_rst_in_ready", 64'(in_ready), 64'd1);
        check("t4_rst_q", 64'(quotient_div), 64'd0);
        check("t4_rst_r", 64'(remainder_div), 64'd0);
        check("t4_rst_dbz", 64'(div_by_zero), 64'd0);
        saw_valid = 1'b0;
        repeat (40) begin
            @(posedge clk);
            #1;
            if (out_valid) saw_valid = 1'b1;
        end
        check("t4_no_emit", 64'(saw_valid), 64'd0);
        run_op("t4_1000_3", 32'd1000, 32'd3, 32'd333, 32'd1, 1'b0, LAT);

`ifdef VEDIC_DIV_SIGNED_EN
        run_op("t6_m7_2", 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 32'hFFFF_FFFF,
               1'b0, W + 1);
        run_op("t6_min_m1", 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000,
               32'd0, 1'b0, W + 1);
`else
        for (int n = 0; n < 200; n++) begin
            a = $urandom;
            b = $urandom >> $urandom_range(0, 31);
            if (b == '0) b = 32'd1;
            out_ready = 1'b0;
            start(a, b);
            wait_out(lat);
            check("t5_lat", 64'(lat), 64'(W));
            check("t5_q", 64'(quotient_div), 64'(a / b));
            check("t5_r", 64'(remainder_div), 64'(a % b));
            check("t5_inv", 64'(quotient_div) * 64'(b) + 64'(remainder_div),
                  64'(a));
            check("t5_rlt", 64'(remainder_div < b), 64'd1);
            repeat ($urandom_range(0, 3)) @(posedge clk);
            #1;
            handshake();
        end
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule

// File: doc/vedic_seq_divider.md
Name: vedic_seq_divider

Overview:
- Iterative restoring divider; the inverse of the vector multiplier datapath.
- Recovers quotient and remainder from a dividend/divisor pair using one shift-subtract step per clock.
- Sits beside the multiplier lanes. Used for result normalisation and for checking multiply results (check: product / operand = other operand, remainder 0).
- Valid/ready handshake on both sides. One operation in flight.

Parameters:
DIVIDER_WIDTH, 32, operand/quotient/remainder width in bits (>= 2)

Ports:
clk  input  1  clock; all state updates on rising edge
rst  input  1  synchronous, active-high reset
in_valid  input  1  operand pair valid
in_ready  output  1  block can accept operands (high only in IDLE)
dividend_div  input  DIVIDER_WIDTH  dividend
divisor_div  input  DIVIDER_WIDTH  divisor
out_valid  output  1  result valid
out_ready  input  1  consumer accepts result
quotient_div  output  DIVIDER_WIDTH  quotient
remainder_div  output  DIVIDER_WIDTH  remainder
div_by_zero  output  1  result came from a zero divisor

Behaviour:
- Reset: clk, synchronous, active-high, as already decided.
  - Reset values: state=IDLE, in_ready=1, out_valid=0, quotient_div=0, remainder_div=0, div_by_zero=0, step counter=0.
  - rst asserted in any state aborts the operation in progress. Nothing is emitted. The block returns to IDLE on the next edge.
- States: IDLE, RUN, DONE.
- IDLE:
  - in_ready=1.
  - On the edge where in_valid && in_ready, the block latches the operands, clears the partial remainder (DIVIDER_WIDTH+1 bits) and loads the counter with DIVIDER_WIDTH.
  - divisor_div != 0 -> next state RUN.
  - divisor_div == 0 -> next state DONE with quotient_div = all ones, remainder_div = dividend_div, div_by_zero=1. Latency 1 cycle.
- RUN:
  - in_ready=0.
  - Each edge: shift {partial remainder, dividend MSB} left by 1, then subtract the divisor in DIVIDER_WIDTH+1-bit two's-complement arithmetic.
  - Difference negative (MSB=1): keep the shifted value, quotient bit=0.
  - Otherwise: take the difference, quotient bit=1.
  - Quotient bits enter at the LSB. The counter decrements.
  - After exactly DIVIDER_WIDTH steps -> DONE. quotient_div and remainder_div are registered on that edge, div_by_zero=0.
  - Latency: out_valid is high in the cycle that starts DIVIDER_WIDTH edges after the accept edge.
- DONE:
  - out_valid=1, in_ready=0.
  - Outputs hold stable while out_ready=0; back-pressure can last any number of cycles.
  - On the edge where out_valid && out_ready -> IDLE.
- No same-cycle pass-through: in_ready is 0 in DONE, so a new operation is accepted no earlier than the cycle after the result handshake.
- quotient_div, remainder_div and div_by_zero keep their last values until the next result load (not cleared on handshake).
- in_valid/operand changes during RUN/DONE are ignored.
- Unsigned default: quotient = floor(dividend/divisor), remainder = dividend - quotient*divisor, remainder < divisor always.
- Invariant: for all divisor != 0, quotient*divisor + remainder == dividend, no wrap.

Optional Feature:
- Macro: VEDIC_DIV_SIGNED_EN.
- Defined:
  - Operands are two's complement.
  - On accept, the block takes magnitudes, runs the unsigned core, then applies the signs.
  - Quotient negated if the operand signs differ (truncation toward zero). Remainder takes the sign of the dividend.
  - Sign fix-up adds one cycle: latency DIVIDER_WIDTH+1 for non-zero divisor.
  - Overflow case MIN / -1: quotient = MIN (0x80000000 at default width), remainder=0, div_by_zero=0.
  - Divide by zero: same as unsigned mode (all-ones quotient, remainder = dividend, flag=1).
- Undefined: purely unsigned; no sign logic synthesised.

Test Plan:
1. dividend=100, divisor=7, out_ready=1 -> out_valid rises 32 cycles after accept; quotient=14, remainder=2, div_by_zero=0; in_ready=1 the cycle after the handshake.
2. dividend=0x00001234, divisor=0 -> next cycle out_valid=1, quotient=0xFFFFFFFF, remainder=0x00001234, div_by_zero=1.
3. dividend=0xFFFFFFFF, divisor=1, out_ready held 0 for 10 cycles after out_valid -> quotient=0xFFFFFFFF, remainder=0 stable all 10 cycles; in_valid pulses meanwhile are ignored (in_ready=0).
4. Accept 1000/3, assert rst at step 16 for one cycle -> no out_valid; all outputs return to reset values; subsequent 1000/3 gives quotient=333, remainder=1.
5. 200 random pairs with non-zero divisor, random out_ready stalls -> quotient*divisor+remainder==dividend and remainder<divisor for every result.
6. (VEDIC_DIV_SIGNED_EN) -7/2 -> quotient=0xFFFFFFFD (-3), remainder=0xFFFFFFFF (-1), latency 33; 0x80000000/0xFFFFFFFF -> quotient=0x80000000, remainder=0.
